gray_fifo_pointer: RTL and testbench
====================================

# gray_fifo_pointer

Parametrised pointer block for one side of a dual-clock FIFO. It keeps a binary and Gray-coded pointer with a wrap bit and registers the Gray output so it is glitch-free for the other clock domain. It synchronises the opposite domain's Gray pointer and derives a registered full flag (write side) or empty flag (read side), a fill level and an almost flag. One instance sits in each clock domain of the clock-crossing FIFO, next to the dual-port RAM.

## Interface
Parameters:
- ADDR_WIDTH, 4: RAM address bits. DEPTH = 2**ADDR_WIDTH. Legal range 2..16.
- MODE, 0: 0 = write side (stop means full); 1 = read side (stop means empty).
- SYNC_STAGES, 2: flip-flop stages on remote_gray_ptr. Legal range 2..4.
- ALMOST_THRESH, 1: almost threshold. Legal range 1..DEPTH-1.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset, synchronous and active-high.
- inc  in  1  request to advance the pointer by one.
- remote_gray_ptr  in  ADDR_WIDTH+1  Gray pointer from the other domain, asynchronous.
- advance  out  1  combinational inc & ~stop; the accepted-increment strobe.
- addr  out  ADDR_WIDTH  RAM address, equal to bin_ptr[ADDR_WIDTH-1:0].
- bin_ptr  out  ADDR_WIDTH+1  registered binary pointer, including the wrap bit.
- gray_ptr  out  ADDR_WIDTH+1  registered Gray pointer, bin_ptr ^ (bin_ptr >> 1).
- stop  out  1  registered full (MODE 0) or empty (MODE 1).
- level  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH.
- almost  out  1  registered; MODE 0: level >= ALMOST_THRESH; MODE 1: level <= ALMOST_THRESH.

## Operation
- Next pointer: bin_next = bin_ptr + advance, modulo 2**(ADDR_WIDTH+1). gray_next = bin_next ^ (bin_next >> 1).
- Wrap: the pointer wraps from 2**(ADDR_WIDTH+1)-1 to 0. Consecutive gray_ptr values always differ in exactly one bit.
- Synchroniser: SYNC_STAGES-deep shift register on remote_gray_ptr, cleared by reset. Output is rgray_s. The synchroniser carries no other logic.
- Gray-to-binary: rbin_s[ADDR_WIDTH] = rgray_s[ADDR_WIDTH]; rbin_s[i] = rbin_s[i+1] ^ rgray_s[i].
- Stop, MODE 0: stop <= (gray_next == {~rgray_s[A:A-1], rgray_s[A-2:0]}), where A = ADDR_WIDTH.
- Stop, MODE 1: stop <= (gray_next == rgray_s).
- Level, MODE 0: level <= bin_next - rbin_s. MODE 1: level <= rbin_s - bin_next. Both are (ADDR_WIDTH+1)-bit modular subtractions.
- almost is computed from the same next-state level value, so it is consistent with level in every cycle.
- Flags are computed from the next-state pointer, so stop asserts in the cycle right after the increment that fills or empties the FIFO.
- Blocking: inc while stop=1 is ignored. The pointer holds and advance=0.
- Simultaneous events: a remote update and a local inc in the same cycle are both applied in the next-state calculation. stop may clear and reassert with no idle cycle.

## Timing
- Reset values:
  - bin_ptr = 0, gray_ptr = 0, addr = 0, level = 0, synchroniser = 0.
  - stop = 0 in MODE 0 and 1 in MODE 1.
  - almost = 0 in MODE 0 and 1 in MODE 1.
- Reset mid-operation: every register returns to its reset value on the first edge with areset=1, and inc is ignored while areset=1.
- Latency from an accepted inc to gray_ptr, bin_ptr, stop and level changing: 1 cycle.
- Latency from a remote_gray_ptr change to stop, level and almost changing: SYNC_STAGES+1 cycles.
- Flags are pessimistic. A stale remote pointer can only make stop assert early or deassert late, never the reverse.
- advance is the only combinational output. All others come directly from flops.

## Test plan
- Fill (MODE 0, ADDR_WIDTH=3, remote held at 0):
  - 8 cycles of inc -> stop=1 in the cycle after the 8th accept, gray_ptr=4'b1100, level=8.
  - A 9th inc -> advance=0 and the pointer does not move.
- Drain release (MODE 1, ADDR_WIDTH=3, SYNC_STAGES=2):
  - Out of reset -> stop=1.
  - Set remote_gray_ptr=4'b0010 (binary 3) -> stop=0, level=3 exactly 3 cycles later.
  - 3 incs -> stop=1, level=0.
- Wrap (MODE 1, ADDR_WIDTH=3, remote advanced ahead each step) -> over 16 accepts, bin_ptr runs 0..15 and back to 0, and every step of gray_ptr has Hamming distance 1.
- Almost (MODE 0, ADDR_WIDTH=3, ALMOST_THRESH=6) -> almost goes 0 to 1 in the cycle level goes 5 to 6, and returns to 0 when the remote read advance makes level=5.
- Simultaneous events (MODE 0, FIFO full) -> a remote pointer advance by 1 plus inc held high gives stop=0 for exactly one cycle, one accept, then stop=1.
- Reset mid-operation (MODE 0, level=5, inc held high) -> pulse areset for 1 cycle; next edge gives bin_ptr=0, gray_ptr=0, level=0, stop=0, synchroniser cleared.

Source files
------------

// File: rtl/gray_fifo_pointer.sv
// Pointer block for one side of a dual-clock FIFO: binary/Gray pointer,
// synchroniser for the remote Gray pointer, and registered full/empty,
// fill level and almost flags derived from the next-state pointer.
module gray_fifo_pointer #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned MODE          = 0,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ALMOST_THRESH = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   remote_gray_ptr,
  output logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   bin_ptr,
  output logic [ADDR_WIDTH:0]   gray_ptr,
  output logic                  stop,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost
);

  localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
  localparam bit          IS_WR  = (MODE == 0);
  // Read side comes out of reset empty, write side comes out not full.
  localparam logic        RST_STOP   = !IS_WR;
  localparam logic        RST_ALMOST = !IS_WR;

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] rgray_s;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] bin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] full_gray;
  logic [PTR_W-1:0] level_next;
  logic             stop_next;
  logic             almost_next;

  // Accepted-increment strobe; the only combinational output.
  assign advance = inc & ~stop;
  assign addr    = bin_ptr[ADDR_WIDTH-1:0];
  assign rgray_s = sync_q[SYNC_STAGES-1];

  // Plain shift-register synchroniser for the remote Gray pointer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= remote_gray_ptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Next-state pointer, remote Gray-to-binary and flag computation.
  always_comb begin
    bin_next  = bin_ptr + PTR_W'(advance);
    gray_next = bin_next ^ (bin_next >> 1);
    rbin_s    = '0;
    for (int unsigned i = 0; i < PTR_W; i++) begin
      rbin_s[i] = ^(rgray_s >> i);
    end
    // Full when the local pointer is exactly one lap ahead of the remote one.
    full_gray = {~rgray_s[ADDR_WIDTH:ADDR_WIDTH-1], rgray_s[ADDR_WIDTH-2:0]};
    if (IS_WR) begin
      stop_next   = (gray_next == full_gray);
      level_next  = bin_next - rbin_s;
      almost_next = (level_next >= PTR_W'(ALMOST_THRESH));
    end else begin
      stop_next   = (gray_next == rgray_s);
      level_next  = rbin_s - bin_next;
      almost_next = (level_next <= PTR_W'(ALMOST_THRESH));
    end
  end

  // Pointer and flag registers; Gray output is registered to stay glitch-free.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      stop     <= RST_STOP;
      level    <= '0;
      almost   <= RST_ALMOST;
    end else begin
      bin_ptr  <= bin_next;
      gray_ptr <= gray_next;
      stop     <= stop_next;
      level    <= level_next;
      almost   <= almost_next;
    end
  end

endmodule

// File: tb/tb_gray_fifo_pointer.sv
// Directed bench: write-side instance driven from a vector table, read-side
// instance exercised with hand-written drain and wrap sequences.
module tb_gray_fifo_pointer;

  logic       aclk;
  logic       areset;
  logic       inc_w, inc_r;
  logic [3:0] rem_w, rem_r;
  logic       adv_w, adv_r;
  logic [2:0] addr_w, addr_r;
  logic [3:0] bin_w, bin_r, gray_w, gray_r, lvl_w, lvl_r;
  logic       stop_w, stop_r, alm_w, alm_r;

  int tests = 0;
  int fails = 0;

  gray_fifo_pointer #(.ADDR_WIDTH(3), .MODE(0), .SYNC_STAGES(2), .ALMOST_THRESH(6)) dut_w (
    .aclk(aclk), .areset(areset), .inc(inc_w), .remote_gray_ptr(rem_w),
    .advance(adv_w), .addr(addr_w), .bin_ptr(bin_w), .gray_ptr(gray_w),
    .stop(stop_w), .level(lvl_w), .almost(alm_w)
  );

  gray_fifo_pointer #(.ADDR_WIDTH(3), .MODE(1), .SYNC_STAGES(2), .ALMOST_THRESH(1)) dut_r (
    .aclk(aclk), .areset(areset), .inc(inc_r), .remote_gray_ptr(rem_r),
    .advance(adv_r), .addr(addr_r), .bin_ptr(bin_r), .gray_ptr(gray_r),
    .stop(stop_r), .level(lvl_r), .almost(alm_r)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic       inc;
    logic [3:0] rem;
    logic       adv;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       stop;
    logic [3:0] level;
    logic       almost;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1;
    inc_w  = 1'b0;
    inc_r  = 1'b0;
    rem_w  = '0;
    rem_r  = '0;

    //          rst   inc   rem      adv   bin   gray     stop  lvl   almost
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd0, 1'b0};
    // fill from empty with remote at 0
    tbl[1]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd1, 4'b0001, 1'b0, 4'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd2, 4'b0011, 1'b0, 4'd2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd3, 4'b0010, 1'b0, 4'd3, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd4, 4'b0110, 1'b0, 4'd4, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd5, 4'b0111, 1'b0, 4'd5, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd6, 4'b0101, 1'b0, 4'd6, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd7, 4'b0100, 1'b0, 4'd7, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'd8, 4'b1100, 1'b1, 4'd8, 1'b1};
    // blocked inc while full
    tbl[9]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 1'b1, 4'd8, 1'b1};
    // remote read pointer jumps to 3: visible after 3 edges
    tbl[10] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b1, 4'd8, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b1, 4'd8, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'd8, 4'b1100, 1'b0, 4'd5, 1'b0};
    // refill to full
    tbl[13] = '{1'b0, 1'b1, 4'b0010, 1'b1, 4'd9,  4'b1101, 1'b0, 4'd6, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'b0010, 1'b1, 4'd10, 4'b1111, 1'b0, 4'd7, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 4'b0010, 1'b1, 4'd11, 4'b1110, 1'b1, 4'd8, 1'b1};
    // remote advances by one with inc held: one free cycle, one accept
    tbl[16] = '{1'b0, 1'b1, 4'b0110, 1'b0, 4'd11, 4'b1110, 1'b1, 4'd8, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 4'b0110, 1'b0, 4'd11, 4'b1110, 1'b1, 4'd8, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 4'b0110, 1'b0, 4'd11, 4'b1110, 1'b0, 4'd7, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 4'b0110, 1'b1, 4'd12, 4'b1010, 1'b1, 4'd8, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 4'b0110, 1'b0, 4'd12, 4'b1010, 1'b1, 4'd8, 1'b1};
    // remote moves to 7 -> level 5
    tbl[21] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'd12, 4'b1010, 1'b1, 4'd8, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'd12, 4'b1010, 1'b1, 4'd8, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'd12, 4'b1010, 1'b0, 4'd5, 1'b0};
    // reset pulse with inc held; synchroniser must come back cleared
    tbl[24] = '{1'b1, 1'b1, 4'b0100, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd0, 1'b0};

    tick();
    for (int i = 0; i < NV; i++) begin
      areset = tbl[i].rst;
      inc_w  = tbl[i].inc;
      rem_w  = tbl[i].rem;
      #1;
      if (!tbl[i].rst) check($sformatf("w%0d advance", i), 32'(adv_w), 32'(tbl[i].adv));
      tick();
      check($sformatf("w%0d bin_ptr", i),  32'(bin_w),  32'(tbl[i].bin));
      check($sformatf("w%0d addr", i),     32'(addr_w), 32'(tbl[i].bin[2:0]));
      check($sformatf("w%0d gray_ptr", i), 32'(gray_w), 32'(tbl[i].gray));
      check($sformatf("w%0d stop", i),     32'(stop_w), 32'(tbl[i].stop));
      check($sformatf("w%0d level", i),    32'(lvl_w),  32'(tbl[i].level));
      check($sformatf("w%0d almost", i),   32'(alm_w),  32'(tbl[i].almost));
    end
    inc_w = 1'b0;

    // Read side: reset state is empty
    areset = 1'b1;
    inc_r  = 1'b0;
    rem_r  = '0;
    tick();
    check("r reset stop",   32'(stop_r), 32'd1);
    check("r reset almost", 32'(alm_r),  32'd1);
    check("r reset level",  32'(lvl_r),  32'd0);
    check("r reset bin",    32'(bin_r),  32'd0);
    areset = 1'b0;

    // Drain release: remote write pointer to 3, visible exactly 3 edges later
    rem_r = 4'b0010;
    tick();
    check("r release e1 stop", 32'(stop_r), 32'd1);
    tick();
    check("r release e2 stop", 32'(stop_r), 32'd1);
    tick();
    check("r release e3 stop",   32'(stop_r), 32'd0);
    check("r release e3 level",  32'(lvl_r),  32'd3);
    check("r release e3 almost", 32'(alm_r),  32'd0);

    inc_r = 1'b1;
    #1;
    check("r pop1 advance", 32'(adv_r), 32'd1);
    tick();
    check("r pop1 level",  32'(lvl_r),  32'd2);
    check("r pop1 stop",   32'(stop_r), 32'd0);
    check("r pop1 almost", 32'(alm_r),  32'd0);
    tick();
    check("r pop2 level",  32'(lvl_r),  32'd1);
    check("r pop2 almost", 32'(alm_r),  32'd1);
    tick();
    check("r pop3 level", 32'(lvl_r),  32'd0);
    check("r pop3 stop",  32'(stop_r), 32'd1);
    check("r pop3 gray",  32'(gray_r), 32'b0010);
    #1;
    check("r pop4 advance", 32'(adv_r), 32'd0);
    tick();
    check("r pop4 bin", 32'(bin_r), 32'd3);
    inc_r = 1'b0;

    // Wrap: keep the remote pointer ahead, 16 accepts around the full range
    areset = 1'b1;
    tick();
    areset = 1'b0;
    rem_r  = g4(4'd4);
    tick();
    tick();
    tick();
    check("r wrap pre stop",  32'(stop_r), 32'd0);
    check("r wrap pre level", 32'(lvl_r),  32'd4);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] prev_gray;
      logic [3:0] exp_bin;
      exp_bin   = 4'(k + 1);
      prev_gray = gray_r;
      rem_r     = g4(4'(k + 5));
      inc_r     = 1'b1;
      #1;
      check($sformatf("r wrap%0d advance", k), 32'(adv_r), 32'd1);
      tick();
      check($sformatf("r wrap%0d bin", k),  32'(bin_r),  32'(exp_bin));
      check($sformatf("r wrap%0d gray", k), 32'(gray_r), 32'(g4(exp_bin)));
      check($sformatf("r wrap%0d hamming", k), 32'($countones(gray_r ^ prev_gray)), 32'd1);
      check($sformatf("r wrap%0d stop", k), 32'(stop_r), 32'd0);
    end
    inc_r = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
